data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Byte-addressed data memory with request/response handshake, RV32 byte-lane stores,
//  sign/zero-extended loads, misalignment detection and programmable wait states.
//  Sits between the MEM-stage load/store unit and the storage array; replaces direct
//  word-indexed array access so the core can be tested against slower memory timing.
// PARAMETERS
//  P_ADDR_WIDTH   13  byte-address width; depth = 2**(P_ADDR_WIDTH-2) 32-bit words
//  P_DATA_WIDTH   32  data width; only 32 supported (elaboration error otherwise)
//  P_WAIT_CYCLES  1   extra cycles between acceptance and memory access (0..15)
// PORTS
//  i_clk         in   1             clock, all state on rising edge
//  i_rst         in   1             asynchronous, active-high reset
//  i_req         in   1             request valid; held by requester until accepted
//  i_we          in   1             1 = store, 0 = load
//  i_addr        in   P_ADDR_WIDTH  byte address
//  i_size        in   2             00 byte, 01 half, 10 word, 11 illegal
//  i_unsigned    in   1             loads: 1 = zero-extend (LBU/LHU), 0 = sign-extend
//  i_wdata       in   32            store data, right-aligned (byte in [7:0], half in [15:0])
//  o_ready       out  1             1 in IDLE only; accept = i_req & o_ready at rising edge
//  o_rvalid      out  1             one-cycle response pulse (loads and stores)
//  o_err         out  1             valid with o_rvalid; 1 = misaligned/illegal access
//  o_rdata       out  32            registered load result; stable until next response
// BEHAVIOUR
//  - Reset (async): state IDLE, wait counter 0, o_rvalid 0, o_err 0, o_rdata 0, o_ready 1.
//    Array contents are not reset.
//  - FSM: IDLE -> (accept) -> WAIT if P_WAIT_CYCLES>0, else access on accept edge -> RESP.
//    WAIT: counter loaded with P_WAIT_CYCLES at accept, decrements each edge; at the edge
//    where counter==1 the access is performed and FSM -> RESP. RESP: o_rvalid=1, o_ready=0,
//    next edge -> IDLE. o_rvalid high exactly P_WAIT_CYCLES+1 edges after the accept edge.
//  - Throughput: one request per P_WAIT_CYCLES+2 cycles; i_req outside IDLE is ignored.
//  - addr, we, size, unsigned, wdata captured at accept; later input changes have no effect.
//  - Word index = addr[P_ADDR_WIDTH-1:2]; lane = addr[1:0].
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11. Checked at accept;
//    access is suppressed (no array write), response gives o_err=1, o_rdata=0.
//  - Stores: SB writes wdata[7:0] to lane addr[1:0]; SH writes wdata[15:0] to half addr[1];
//    SW writes all 32 bits; other lanes untouched. o_rdata unchanged, o_err=0.
//  - Loads: byte/half extracted from lane, extended per i_unsigned; word returned as-is.
//  - i_unsigned ignored for word loads and for stores.
//  - Reset mid-operation (WAIT or RESP): aborted; pending store not written, no o_rvalid.
// TESTING
//  1. SW 0xDEADBEEF @0x10, LW @0x10 -> o_rdata 0xDEADBEEF, o_err 0, o_rvalid P_WAIT_CYCLES+1
//     edges after each accept.
//  2. After (1): SB 0x80 @0x13; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080;
//     LW @0x10 -> 0x80ADBEEF.
//  3. SW 0xDEADBEEF @0x20, SH 0x1234 @0x22; LW @0x20 -> 0x1234BEEF;
//     LH @0x20 -> 0xFFFFBEEF; LHU @0x20 -> 0x0000BEEF.
//  4. LW @0x11 -> o_err 1, o_rdata 0; SH 0xAAAA @0x21 -> o_err 1; LW @0x20 still 0x1234BEEF.
//  5. P_WAIT_CYCLES=3: SW 0x55 @0x30, assert i_rst during WAIT -> no o_rvalid, o_ready 1;
//     after reset, LW @0x30 differs from 0x55 (store aborted).
//  6. i_req held high continuously with new addresses -> accepts only in IDLE, one per
//     P_WAIT_CYCLES+2 cycles; changing i_addr during WAIT does not alter the result.

Source files
------------

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Brief    : Byte-addressed data memory with req/resp handshake, byte-lane
//            stores, sign/zero-extended loads and programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
  parameter int P_ADDR_WIDTH  = 13,
  parameter int P_DATA_WIDTH  = 32,
  parameter int P_WAIT_CYCLES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [P_ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]              i_size,
  input  logic                    i_unsigned,
  input  logic [P_DATA_WIDTH-1:0] i_wdata,
  output logic                    o_ready,
  output logic                    o_rvalid,
  output logic                    o_err,
  output logic [P_DATA_WIDTH-1:0] o_rdata
);

  localparam int         C_IDX_W = P_ADDR_WIDTH - 2;
  localparam int         C_DEPTH = 2 ** C_IDX_W;
  localparam logic [3:0] C_WAIT  = 4'(P_WAIT_CYCLES);

  if (P_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("data_memory_ctrl: P_DATA_WIDTH must be 32");
  end
  if (P_WAIT_CYCLES < 0 || P_WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("data_memory_ctrl: P_WAIT_CYCLES must be within 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                    state_q;
  logic [3:0]                cnt_q;
  logic                      ready_q;
  logic                      rvalid_q;
  logic                      err_q;
  logic [31:0]               rdata_q;
  logic [P_ADDR_WIDTH-1:0]   addr_q;
  logic                      we_q;
  logic [1:0]                size_q;
  logic                      uns_q;
  logic [31:0]               wdata_q;
  logic                      mis_q;

  logic [31:0]               mem_q [C_DEPTH];

  logic                      w_accept;
  logic                      w_in_idle;
  logic                      w_mis_in;
  logic                      w_do_access;
  logic                      w_write;
  logic [P_ADDR_WIDTH-1:0]   w_addr;
  logic                      w_we;
  logic [1:0]                w_size;
  logic                      w_uns;
  logic [31:0]               w_wdata;
  logic                      w_mis;
  logic [1:0]                w_lane;
  logic [C_IDX_W-1:0]        w_idx;
  logic [31:0]               w_word;
  logic [31:0]               w_load;
  logic [3:0]                w_be;
  logic [31:0]               w_wlanes;

  function automatic logic f_misaligned(input logic [1:0] lane, input logic [1:0] size);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lane,
                                         input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign w_accept  = i_req & ready_q & ~i_rst;
  assign w_in_idle = (state_q == ST_IDLE);
  assign w_mis_in  = f_misaligned(i_addr[1:0], i_size);

  // With zero wait states the access happens on the accept edge, so the
  // live inputs are used; otherwise the operands captured at accept are.
  assign w_addr  = w_in_idle ? i_addr     : addr_q;
  assign w_we    = w_in_idle ? i_we       : we_q;
  assign w_size  = w_in_idle ? i_size     : size_q;
  assign w_uns   = w_in_idle ? i_unsigned : uns_q;
  assign w_wdata = w_in_idle ? i_wdata    : wdata_q;
  assign w_mis   = w_in_idle ? w_mis_in   : mis_q;

  assign w_do_access = ~i_rst & ((w_accept & (C_WAIT == 4'd0)) |
                                 ((state_q == ST_WAIT) & (cnt_q == 4'd1)));
  assign w_write     = w_do_access & w_we & ~w_mis;

  assign w_lane = w_addr[1:0];
  assign w_idx  = w_addr[P_ADDR_WIDTH-1:2];
  assign w_word = mem_q[w_idx];
  assign w_load = f_load(w_word, w_lane, w_size, w_uns);

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = w_wdata;
    case (w_size)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_wdata[15:0]}};
      end
      2'b10: begin
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
      end
      default: begin
        w_be     = 4'b0000;
        w_wlanes = w_wdata;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      wdata_q  <= 32'd0;
      mis_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (w_do_access) begin
        state_q  <= ST_RESP;
        cnt_q    <= 4'd0;
        ready_q  <= 1'b0;
        rvalid_q <= 1'b1;
        err_q    <= w_mis;
        if (w_mis)      rdata_q <= 32'd0;
        else if (!w_we) rdata_q <= w_load;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (w_accept) begin
              addr_q  <= i_addr;
              we_q    <= i_we;
              size_q  <= i_size;
              uns_q   <= i_unsigned;
              wdata_q <= i_wdata;
              mis_q   <= w_mis_in;
              cnt_q   <= C_WAIT;
              ready_q <= 1'b0;
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            cnt_q <= cnt_q - 4'd1;
          end
          ST_RESP: begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_ready  = ready_q;
  assign o_rvalid = rvalid_q;
  assign o_err    = err_q;
  assign o_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ctrl
// Brief    : Directed and randomized checks of data_memory_ctrl against a
//            byte-array reference model of the memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ctrl;

  localparam int C_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [12:0] addr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [0:8191];
  logic [31:0] ref_last = 32'd0;

  data_memory_ctrl #(
    .P_ADDR_WIDTH (13),
    .P_DATA_WIDTH (32),
    .P_WAIT_CYCLES(C_W)
  ) u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_we      (we),
    .i_addr    (addr),
    .i_size    (size),
    .i_unsigned(uns),
    .i_wdata   (wdata),
    .o_ready   (ready),
    .o_rvalid  (rvalid),
    .o_err     (err),
    .o_rdata   (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_mis(input logic [12:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [12:0] a, input logic [1:0] s, input logic u);
    int          base;
    logic [31:0] v;
    base = int'(a);
    if (s == 2'd0) begin
      v = {24'd0, ref_mem[base]};
      if (!u && v[7]) v = v | 32'hFFFFFF00;
    end else if (s == 2'd1) begin
      v = {16'd0, ref_mem[base+1], ref_mem[base]};
      if (!u && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    end
    return v;
  endfunction

  task automatic m_store(input logic [12:0] a, input logic [1:0] s, input logic [31:0] d);
    int n;
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  // One complete transaction; inputs are scrambled right after acceptance.
  task automatic do_op(input string tag, input logic w, input logic [12:0] a,
                       input logic [1:0] s, input logic u, input logic [31:0] d,
                       output logic [31:0] rd);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          lat;
    exp_err = m_mis(a, s);
    if (exp_err)   exp_rd = 32'd0;
    else if (!w)   exp_rd = m_load(a, s, u);
    else           exp_rd = ref_last;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    req = 1'b1; we = w; addr = a; size = s; uns = u; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = $urandom_range(0, 1); addr = 13'($urandom);
    size = 2'($urandom); uns = $urandom_range(0, 1); wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rvalid && lat < 40);
    chk({tag, "_lat"}, lat, C_W + 1);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rdata, exp_rd);
    rd = rdata;
    if (w && !exp_err) m_store(a, s, d);
    ref_last = exp_rd;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_q [$];
    int          accepts;
    int          last_acc;
    int          seen_rvalid;
    logic [12:0] ra;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = 2'd0; uns = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    do_op("t1_sw", 1, 13'h10, 2'd2, 0, 32'hDEADBEEF, rd);
    do_op("t1_lw", 0, 13'h10, 2'd2, 0, 32'h0, rd);
    chk("t1_lw_const", rd, 32'hDEADBEEF);

    do_op("t2_sb", 1, 13'h13, 2'd0, 0, 32'h00000080, rd);
    do_op("t2_lb", 0, 13'h13, 2'd0, 0, 32'h0, rd);
    chk("t2_lb_const", rd, 32'hFFFFFF80);
    do_op("t2_lbu", 0, 13'h13, 2'd0, 1, 32'h0, rd);
    chk("t2_lbu_const", rd, 32'h00000080);
    do_op("t2_lw", 0, 13'h10, 2'd2, 1, 32'h0, rd);
    chk("t2_lw_const", rd, 32'h80ADBEEF);

    do_op("t3_sw", 1, 13'h20, 2'd2, 0, 32'hDEADBEEF, rd);
    do_op("t3_sh", 1, 13'h22, 2'd1, 0, 32'h00001234, rd);
    do_op("t3_lw", 0, 13'h20, 2'd2, 0, 32'h0, rd);
    chk("t3_lw_const", rd, 32'h1234BEEF);
    do_op("t3_lh", 0, 13'h20, 2'd1, 0, 32'h0, rd);
    chk("t3_lh_const", rd, 32'hFFFFBEEF);
    do_op("t3_lhu", 0, 13'h20, 2'd1, 1, 32'h0, rd);
    chk("t3_lhu_const", rd, 32'h0000BEEF);

    do_op("t4_lw_mis", 0, 13'h11, 2'd2, 0, 32'h0, rd);
    do_op("t4_sh_mis", 1, 13'h21, 2'd1, 0, 32'h0000AAAA, rd);
    do_op("t4_size3", 0, 13'h20, 2'd3, 0, 32'h0, rd);
    do_op("t4_lw", 0, 13'h20, 2'd2, 0, 32'h0, rd);
    chk("t4_lw_const", rd, 32'h1234BEEF);

    // Store aborted by reset while waiting.
    do_op("t5_pre", 1, 13'h30, 2'd2, 0, 32'hCAFEF00D, rd);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 13'h30; size = 2'd2; uns = 1'b0; wdata = 32'h00000055;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("t5_rst_ready", {31'd0, ready}, 32'd1);
    chk("t5_rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("t5_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_last = 32'd0;
    seen_rvalid = 0;
    repeat (C_W + 3) begin
      @(negedge clk);
      if (rvalid) seen_rvalid++;
    end
    chk("t5_no_rvalid", seen_rvalid, 0);
    do_op("t5_lw", 0, 13'h30, 2'd2, 0, 32'h0, rd);
    chk("t5_lw_const", rd, 32'hCAFEF00D);

    // Randomized region: initialise, then mixed operations.
    for (int i = 0; i < 16; i++)
      do_op("rnd_fill", 1, 13'(13'h100 + 4 * i), 2'd2, 0, $urandom, rd);
    for (int i = 0; i < 40; i++)
      do_op("rnd_op", 1'($urandom_range(0, 1)), 13'(13'h100 + $urandom_range(0, 60)),
            2'($urandom), 1'($urandom_range(0, 1)), $urandom, rd);

    // Request held high continuously with a new address every cycle.
    accepts = 0; last_acc = -1;
    @(negedge clk);
    for (int c = 0; c < 5 * (C_W + 2); c++) begin
      if (c != 0) @(negedge clk);
      if (rvalid) begin
        chk("t6_rdata", rdata, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXXXXXX);
        chk("t6_err", {31'd0, err}, 32'd0);
      end
      ra = 13'(13'h100 + 4 * $urandom_range(0, 15));
      req = 1'b1; we = 1'b0; addr = ra; size = 2'd2; uns = 1'b0; wdata = $urandom;
      if (ready) begin
        if (last_acc >= 0) chk("t6_gap", c - last_acc, C_W + 2);
        last_acc = c;
        accepts++;
        exp_q.push_back(m_load(ra, 2'd2, 1'b0));
      end
    end
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (rvalid) chk("t6_drain", rdata, exp_q.pop_front());
    end
    chk("t6_accepts", accepts, 5);
    chk("t6_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
